// File: rtl/ic_cpu_bus_arbiter_pkg.sv
// Shared definitions for the CPU bus arbiter: FSM state encodings and port indices.
package ic_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_REQ  = 2'd1,
        ARB_RSP  = 2'd2
    } arb_state_e;

    localparam logic ARB_PORT_INSTR = 1'b0;
    localparam logic ARB_PORT_DATA  = 1'b1;

endpackage

// File: rtl/ic_cpu_bus_arbiter_if.sv
// CPU memory bus port: req/gnt request channel plus recv/ack response channel.
interface ic_cpu_bus_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic            req;
    logic            gnt;
    logic            wen;
    logic [DW/8-1:0] strb;
    logic [DW-1:0]   wdata;
    logic [AW-1:0]   addr;
    logic            recv;
    logic            ack;
    logic            error;
    logic [DW-1:0]   rdata;

    // master issues requests and accepts responses; slave serves them
    modport master (
        output req, wen, strb, wdata, addr, ack,
        input  gnt, recv, error, rdata
    );
    modport slave (
        input  req, wen, strb, wdata, addr, ack,
        output gnt, recv, error, rdata
    );
endinterface

// File: rtl/ic_cpu_bus_arbiter_rr2.sv
// Two-way priority picker: a lone requester wins, a tie goes to the prio port.
module ic_arb_rr2 (
    input  logic [1:0] req,
    input  logic       prio,
    output logic       winner
);
    always_comb begin
        winner = prio;
        if (req == 2'b01) begin
            winner = 1'b0;
        end else if (req == 2'b10) begin
            winner = 1'b1;
        end
    end
endmodule

// File: rtl/ic_cpu_bus_arbiter.sv
// Shares one CPU bus port between instruction (s0) and data (s1) requesters.
// Define IC_CPU_BUS_ARBITER_ROUND_ROBIN_EN for round-robin tie breaking; otherwise data always wins ties.
module ic_cpu_bus_arbiter
    import ic_pkg::*;
#(
    parameter int AW = 32,
    parameter int DW = 32
) (
    input  logic          m0_aclk,
    input  logic          m0_aresetn,
    ic_cpu_bus_if.slave   s0,
    ic_cpu_bus_if.slave   s1,
    ic_cpu_bus_if.master  mem
);
    arb_state_e      fsm_q, fsm_d;
    logic            owner_q, owner_d;
    logic            prio;
    logic            winner;
    logic            sel;
    logic            granted;
    logic [1:0]      req_v, ack_v;
    logic [1:0]      gnt_v, recv_v;
    logic            mem_req_c, mem_ack_c;
    logic [AW-1:0]   addr_sel;
    logic [DW-1:0]   wdata_sel;
    logic [DW/8-1:0] strb_sel;

    assign req_v = {s1.req, s0.req};
    assign ack_v = {s1.ack, s0.ack};

    ic_arb_rr2 u_pick (
        .req    (req_v),
        .prio   (prio),
        .winner (winner)
    );

`ifdef IC_CPU_BUS_ARBITER_ROUND_ROBIN_EN
    logic prio_q, prio_d;

    always_comb begin
        prio_d = prio_q;
        if (granted) begin
            prio_d = ~sel;
        end
    end

    always_ff @(posedge m0_aclk or negedge m0_aresetn) begin
        if (!m0_aresetn) begin
            prio_q <= ARB_PORT_DATA;
        end else begin
            prio_q <= prio_d;
        end
    end

    assign prio = prio_q;
`else
    assign prio = ARB_PORT_DATA;
`endif

    always_comb begin
        fsm_d     = fsm_q;
        owner_d   = owner_q;
        sel       = owner_q;
        granted   = 1'b0;
        gnt_v     = 2'b00;
        recv_v    = 2'b00;
        mem_req_c = 1'b0;
        mem_ack_c = 1'b0;
        unique case (fsm_q)
            ARB_IDLE: begin
                sel = winner;
                if (|req_v) begin
                    mem_req_c = 1'b1;
                    owner_d   = winner;
                    if (mem.gnt) begin
                        gnt_v[winner] = 1'b1;
                        granted       = 1'b1;
                        fsm_d         = ARB_RSP;
                    end else begin
                        fsm_d = ARB_REQ;
                    end
                end
            end
            ARB_REQ: begin
                // winner stays locked until granted or it abandons the request
                if (!req_v[owner_q]) begin
                    fsm_d = ARB_IDLE;
                end else begin
                    mem_req_c = 1'b1;
                    if (mem.gnt) begin
                        gnt_v[owner_q] = 1'b1;
                        granted        = 1'b1;
                        fsm_d          = ARB_RSP;
                    end
                end
            end
            ARB_RSP: begin
                recv_v[owner_q] = mem.recv;
                mem_ack_c       = ack_v[owner_q];
                if (mem.recv && ack_v[owner_q]) begin
                    fsm_d = ARB_IDLE;
                end
            end
            default: fsm_d = ARB_IDLE;
        endcase
    end

    always_ff @(posedge m0_aclk or negedge m0_aresetn) begin
        if (!m0_aresetn) begin
            fsm_q   <= ARB_IDLE;
            owner_q <= ARB_PORT_INSTR;
        end else begin
            fsm_q   <= fsm_d;
            owner_q <= owner_d;
        end
    end

    assign addr_sel  = sel ? s1.addr  : s0.addr;
    assign wdata_sel = sel ? s1.wdata : s0.wdata;
    assign strb_sel  = sel ? s1.strb  : s0.strb;

    // handshake outputs are forced low while reset is held, even with requests pending
    assign mem.req   = m0_aresetn & mem_req_c;
    assign mem.ack   = m0_aresetn & mem_ack_c;
    assign mem.wen   = sel ? s1.wen : s0.wen;
    assign mem.addr  = addr_sel;
    assign mem.wdata = wdata_sel;
    assign mem.strb  = strb_sel;

    assign s0.gnt    = m0_aresetn & gnt_v[0];
    assign s1.gnt    = m0_aresetn & gnt_v[1];
    assign s0.recv   = m0_aresetn & recv_v[0];
    assign s1.recv   = m0_aresetn & recv_v[1];
    assign s0.rdata  = mem.rdata;
    assign s1.rdata  = mem.rdata;
    assign s0.error  = mem.error;
    assign s1.error  = mem.error;
endmodule

// File: tb/tb_ic_cpu_bus_arbiter.sv
// Self-checking bench for ic_cpu_bus_arbiter: directed scenarios then randomized traffic vs a transaction model.
module tb_ic_cpu_bus_arbiter;
    import ic_pkg::*;

    localparam int AW = 32;
    localparam int DW = 32;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    ic_cpu_bus_if #(.AW(AW), .DW(DW)) s0_if ();
    ic_cpu_bus_if #(.AW(AW), .DW(DW)) s1_if ();
    ic_cpu_bus_if #(.AW(AW), .DW(DW)) mem_if ();

    ic_cpu_bus_arbiter #(.AW(AW), .DW(DW)) dut (
        .m0_aclk    (clk),
        .m0_aresetn (rst_n),
        .s0         (s0_if),
        .s1         (s1_if),
        .mem        (mem_if)
    );

    // Model: is a transaction in flight, has its request been granted, who owns it, who wins ties
    bit          busy;
    bit          rsp_phase;
    bit          m_owner;
    bit          m_prio;

    logic [1:0]  o_gnt, o_recv;
    logic        o_mem_req, o_mem_ack, o_err1;
    logic [31:0] o_rdata0;
    logic [68:0] o_fields;

    bit          pend;
    bit          prev_done;
    int          n_gnt;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        busy      = 1'b0;
        rsp_phase = 1'b0;
        m_owner   = 1'b0;
        m_prio    = 1'b1;
    endtask

    task automatic idle_inputs();
        s0_if.req = 1'b0; s0_if.wen = 1'b0; s0_if.strb = '0; s0_if.wdata = '0; s0_if.addr = '0; s0_if.ack = 1'b0;
        s1_if.req = 1'b0; s1_if.wen = 1'b0; s1_if.strb = '0; s1_if.wdata = '0; s1_if.addr = '0; s1_if.ack = 1'b0;
        mem_if.gnt = 1'b0; mem_if.recv = 1'b0; mem_if.error = 1'b0; mem_if.rdata = '0;
    endtask

    task automatic one_cycle();
        logic [1:0]  rq, ak, eg, er;
        logic        emr, ema, pick, sel_valid;
        logic [68:0] exp_fields;
        @(negedge clk);
        rq = {s1_if.req, s0_if.req};
        ak = {s1_if.ack, s0_if.ack};
        eg = 2'b00; er = 2'b00; emr = 1'b0; ema = 1'b0; pick = 1'b0; sel_valid = 1'b0;
        if (rst_n) begin
            if (!busy) begin
                if (rq != 2'b00) begin
                    pick = (rq == 2'b11) ? m_prio : rq[1];
                    emr = 1'b1; sel_valid = 1'b1;
                    eg[pick] = mem_if.gnt;
                end
            end else if (!rsp_phase) begin
                pick = m_owner;
                if (rq[m_owner]) begin
                    emr = 1'b1; sel_valid = 1'b1;
                    eg[pick] = mem_if.gnt;
                end
            end else begin
                er[m_owner] = mem_if.recv;
                ema = ak[m_owner];
            end
        end
        o_gnt     = {s1_if.gnt, s0_if.gnt};
        o_recv    = {s1_if.recv, s0_if.recv};
        o_mem_req = mem_if.req;
        o_mem_ack = mem_if.ack;
        o_rdata0  = s0_if.rdata;
        o_err1    = s1_if.error;
        o_fields  = {mem_if.wen, mem_if.strb, mem_if.wdata, mem_if.addr};
        check("gnt", 128'(o_gnt), 128'(eg));
        check("recv", 128'(o_recv), 128'(er));
        check("mem_req", 128'(o_mem_req), 128'(emr));
        check("mem_ack", 128'(o_mem_ack), 128'(ema));
        if (sel_valid) begin
            exp_fields = pick ? {s1_if.wen, s1_if.strb, s1_if.wdata, s1_if.addr}
                              : {s0_if.wen, s0_if.strb, s0_if.wdata, s0_if.addr};
            check("mem_fields", 128'(o_fields), 128'(exp_fields));
        end
        if (er != 2'b00) begin
            check("rsp_bcast", 128'({s0_if.error, s0_if.rdata, s1_if.error, s1_if.rdata}),
                  128'({mem_if.error, mem_if.rdata, mem_if.error, mem_if.rdata}));
        end
        @(posedge clk);
        if (!rst_n) begin
            model_reset();
        end else if (!busy) begin
            if (rq != 2'b00) begin
                busy    = 1'b1;
                m_owner = pick;
                if (mem_if.gnt) begin
                    rsp_phase = 1'b1;
`ifdef IC_CPU_BUS_ARBITER_ROUND_ROBIN_EN
                    m_prio = ~pick;
`endif
                end
            end
        end else if (!rsp_phase) begin
            if (!rq[m_owner]) begin
                busy = 1'b0;
            end else if (mem_if.gnt) begin
                rsp_phase = 1'b1;
`ifdef IC_CPU_BUS_ARBITER_ROUND_ROBIN_EN
                m_prio = ~pick;
`endif
            end
        end else if (mem_if.recv && ak[m_owner]) begin
            busy      = 1'b0;
            rsp_phase = 1'b0;
        end
        #1;
    endtask

    task automatic apply_reset();
        idle_inputs();
        rst_n = 1'b0;
        one_cycle();
        rst_n = 1'b1;
    endtask

    initial begin
        idle_inputs();
        model_reset();

        // reset state with every input asserted
        s0_if.req = 1'b1; s1_if.req = 1'b1; mem_if.gnt = 1'b1; mem_if.recv = 1'b1;
        s0_if.ack = 1'b1; s1_if.ack = 1'b1;
        #3;
        check("rst_outputs", 128'({s0_if.gnt, s1_if.gnt, s0_if.recv, s1_if.recv, mem_if.req, mem_if.ack}), 128'(0));
        one_cycle();
        idle_inputs();
        rst_n = 1'b1;
        one_cycle();

        // s0 read, same-cycle grant, response two cycles later
        s0_if.req = 1'b1; s0_if.wen = 1'b0; s0_if.addr = 32'h1000; mem_if.gnt = 1'b1;
        one_cycle();
        check("t1_s0_gnt", 128'(o_gnt), 128'(2'b01));
        s0_if.req = 1'b0; mem_if.gnt = 1'b0;
        one_cycle();
        one_cycle();
        mem_if.recv = 1'b1; mem_if.rdata = 32'hDEADBEEF; s0_if.ack = 1'b1;
        one_cycle();
        check("t1_s0_recv", 128'({o_recv, o_rdata0}), 128'({2'b01, 32'hDEADBEEF}));
        idle_inputs();
        one_cycle();

        // simultaneous requests after reset
        apply_reset();
        s0_if.req = 1'b1; s0_if.addr = 32'h40; s1_if.req = 1'b1; s1_if.addr = 32'h80; mem_if.gnt = 1'b1;
        one_cycle();
        check("t2_tie_first", 128'(o_gnt), 128'(2'b10));
        mem_if.gnt = 1'b0; mem_if.recv = 1'b1; s1_if.ack = 1'b1;
        one_cycle();
        mem_if.recv = 1'b0; s1_if.ack = 1'b0; mem_if.gnt = 1'b1;
        one_cycle();
`ifdef IC_CPU_BUS_ARBITER_ROUND_ROBIN_EN
        check("t2_tie_second", 128'(o_gnt), 128'(2'b01));
`else
        check("t2_tie_second", 128'(o_gnt), 128'(2'b10));
`endif
        s0_if.req = 1'b0; s1_if.req = 1'b0; mem_if.gnt = 1'b0;
        mem_if.recv = 1'b1; s0_if.ack = 1'b1; s1_if.ack = 1'b1;
        one_cycle();
        idle_inputs();
        one_cycle();

        // s1 write stalled downstream; s0 arrives while s1 is locked
        s1_if.req = 1'b1; s1_if.wen = 1'b1; s1_if.addr = 32'h20; s1_if.wdata = 32'h12345678; s1_if.strb = 4'hF;
        for (int c = 0; c < 3; c++) begin
            if (c == 1) begin
                s0_if.req = 1'b1; s0_if.addr = 32'h3000;
            end
            one_cycle();
            check("t3_hold", 128'({o_mem_req, o_fields}), 128'({1'b1, 1'b1, 4'hF, 32'h12345678, 32'h20}));
            check("t3_no_gnt", 128'(o_gnt), 128'(0));
        end
        mem_if.gnt = 1'b1;
        one_cycle();
        check("t3_gnt_s1", 128'(o_gnt), 128'(2'b10));
        s1_if.req = 1'b0; mem_if.gnt = 1'b0;
        mem_if.recv = 1'b1; mem_if.error = 1'b1; mem_if.rdata = 32'h0BAD0BAD; s0_if.ack = 1'b1; s1_if.ack = 1'b0;
        one_cycle();
        check("t4_recv_only_s1", 128'(o_recv), 128'(2'b10));
        check("t4_mem_ack_follows_s1", 128'(o_mem_ack), 128'(0));
        check("t4_s0_waits", 128'(o_gnt), 128'(0));
        s1_if.ack = 1'b1;
        one_cycle();
        check("t4_err_ack", 128'({o_mem_ack, o_err1}), 128'(2'b11));
        mem_if.recv = 1'b0; mem_if.error = 1'b0; s0_if.ack = 1'b0; s1_if.ack = 1'b0; mem_if.gnt = 1'b1;
        one_cycle();
        check("t3_s0_after", 128'(o_gnt), 128'(2'b01));
        s0_if.req = 1'b0; mem_if.gnt = 1'b0; mem_if.recv = 1'b1; s0_if.ack = 1'b1;
        one_cycle();
        idle_inputs();
        one_cycle();

        // asynchronous reset while a response is being delivered
        s0_if.req = 1'b1; s0_if.addr = 32'h500; mem_if.gnt = 1'b1;
        one_cycle();
        mem_if.recv = 1'b1; s0_if.ack = 1'b1;
        #1;
        check("t5_pre_rst", 128'({s0_if.recv, mem_if.ack}), 128'(2'b11));
        rst_n = 1'b0;
        #1;
        check("t5_async_rst", 128'({s0_if.gnt, s1_if.gnt, s0_if.recv, s1_if.recv, mem_if.req, mem_if.ack}), 128'(0));
        one_cycle();
        rst_n = 1'b1; mem_if.recv = 1'b0; s0_if.ack = 1'b0;
        one_cycle();
        check("t5_after_rst", 128'(o_gnt), 128'(2'b01));
        s0_if.req = 1'b0; mem_if.gnt = 1'b0; mem_if.recv = 1'b1; s0_if.ack = 1'b1;
        one_cycle();
        idle_inputs();
        one_cycle();

        // back-to-back s0 with a zero-latency downstream
        s0_if.req = 1'b1; s0_if.addr = 32'h600; mem_if.gnt = 1'b1; mem_if.recv = 1'b1; s0_if.ack = 1'b1;
        n_gnt = 0;
        for (int c = 0; c < 8; c++) begin
            one_cycle();
            prev_done = o_recv[0] & s0_if.ack;
            check("t6_no_overlap", 128'(o_gnt[0] & prev_done), 128'(0));
            n_gnt += int'(o_gnt[0]);
        end
        check("t6_gnt_count", 128'(n_gnt), 128'(4));
        idle_inputs();
        one_cycle();

        // randomized traffic
        pend = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            if (!s0_if.req && $urandom_range(0, 2) == 0) begin
                s0_if.req = 1'b1; s0_if.wen = 1'($urandom_range(0, 1)); s0_if.addr = $urandom;
                s0_if.wdata = $urandom; s0_if.strb = 4'($urandom_range(0, 15));
            end else if (s0_if.req && $urandom_range(0, 63) == 0) begin
                s0_if.req = 1'b0;
            end
            if (!s1_if.req && $urandom_range(0, 1) == 0) begin
                s1_if.req = 1'b1; s1_if.wen = 1'($urandom_range(0, 1)); s1_if.addr = $urandom;
                s1_if.wdata = $urandom; s1_if.strb = 4'($urandom_range(0, 15));
            end else if (s1_if.req && $urandom_range(0, 63) == 0) begin
                s1_if.req = 1'b0;
            end
            s0_if.ack = 1'($urandom_range(0, 1));
            s1_if.ack = 1'($urandom_range(0, 1));
            if (!pend) begin
                mem_if.gnt = 1'($urandom_range(0, 1));
                mem_if.recv = 1'b0;
            end else begin
                mem_if.gnt = 1'b0;
                if (!mem_if.recv && $urandom_range(0, 1) == 0) begin
                    mem_if.recv = 1'b1; mem_if.rdata = $urandom;
                    mem_if.error = ($urandom_range(0, 7) == 0);
                end
            end
            one_cycle();
            if (o_gnt[0]) s0_if.req = 1'b0;
            if (o_gnt[1]) s1_if.req = 1'b0;
            if (o_mem_req && mem_if.gnt) pend = 1'b1;
            if (mem_if.recv && o_mem_ack) begin
                pend = 1'b0;
                mem_if.recv = 1'b0;
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/ic_cpu_bus_arbiter.md
Name: ic_cpu_bus_arbiter

Overview:
- Shares one CPU memory bus port (req/gnt + recv/ack) between two requesters: s0 = instruction fetch, s1 = data load/store.
- Sits between the CPU core and ic_cpu_bus_axi_bridge; its downstream port drives the bridge's mem_* port.
- Exactly one transaction is outstanding at a time. The owner is latched at grant so the response is routed back to the correct requester.

Parameters:
- AW, 32, address width.
- DW, 32, data width; strobe width is DW/8.

Ports:
- m0_aclk  in  1  clock
- m0_aresetn  in  1  reset, asynchronous assert, active-low
- s0_req  in  1  instruction port request
- s0_gnt  out  1  request accepted
- s0_wen  in  1  write enable
- s0_strb  in  DW/8  write strobe
- s0_wdata  in  DW  write data
- s0_addr  in  AW  address
- s0_recv  out  1  response valid
- s0_ack  in  1  response accepted
- s0_error  out  1  response error
- s0_rdata  out  DW  read data
- s1_req, s1_gnt, s1_wen, s1_strb, s1_wdata, s1_addr, s1_recv, s1_ack, s1_error, s1_rdata: same as s0_*, for the data port
- mem_req, mem_wen, mem_strb, mem_wdata, mem_addr: out, widths as above, downstream request
- mem_gnt  in  1  downstream request accepted
- mem_recv  in  1  downstream response valid
- mem_error  in  1  downstream response error
- mem_rdata  in  DW  downstream read data
- mem_ack  out  1  downstream response accepted

Behaviour:
- Protocol rules:
  - Requesters hold req and all request fields stable until gnt.
  - A request completes on req&&gnt.
  - A response completes on recv&&ack.
- State register: fsm (IDLE, REQ, RSP), owner (1 bit), prio (1 bit).
- Reset (async):
  - fsm=IDLE, owner=0, prio=1 (data port favoured).
  - All gnt/recv outputs 0; mem_req 0; mem_ack 0.
- IDLE:
  - Winner w is computed combinationally: only one requesting -> that one; both requesting -> port prio.
  - mem_req = s0_req|s1_req.
  - mem_* request fields are muxed from w.
  - sw_gnt = mem_gnt, where sw is the winner port. The loser's gnt is 0.
  - If mem_gnt: owner<=w, fsm<=RSP.
  - Else if any req: owner<=w, fsm<=REQ. This locks the winner.
- REQ:
  - mem_req = s_owner_req; fields muxed from owner; s_owner_gnt = mem_gnt.
  - The other port is never granted in this state.
  - mem_gnt -> RSP.
  - s_owner_req dropped (protocol violation) -> IDLE; no grant is issued.
- RSP:
  - mem_req=0; both gnt=0.
  - s_owner_recv = mem_recv; the other port's recv is 0.
  - mem_ack = s_owner_ack.
  - mem_recv&&s_owner_ack -> IDLE.
  - A new grant is never issued in the same cycle as a response completes (one idle cycle minimum between transactions).
- s0_rdata = s1_rdata = mem_rdata and s0_error = s1_error = mem_error (broadcast). Only recv qualifies them.
- Latency: arbiter adds zero cycles on the request path (combinational grant in IDLE) and zero on the response path.
- Priority update:
  - On each downstream grant, prio <= ~owner_granted (round-robin), subject to the Optional Feature.
  - With a single requester, that requester is always served.
- A request arriving while in RSP waits; it is arbitrated in the next IDLE cycle.
- Reset mid-transaction returns the FSM to IDLE. The downstream bridge is reset by the same m0_aresetn, so no response is orphaned.

Optional Feature:
- Macro: IC_CPU_BUS_ARBITER_ROUND_ROBIN_EN.
- Defined:
  - prio toggles to the non-granted port on each grant (round-robin).
  - Each port is guaranteed service within two transactions.
- Undefined:
  - prio is constant 1 (data port wins every tie); the prio register is not instantiated.
  - The instruction port can starve under continuous data traffic.

Decomposition:
- Shared package ic_pkg: FSM state encodings (ARB_IDLE=2'd0, ARB_REQ=2'd1, ARB_RSP=2'd2), port index constants (ARB_PORT_INSTR=0, ARB_PORT_DATA=1).
- One sub-module is natural: ic_arb_rr2, a two-way priority picker (req[1:0], prio -> winner). It is purely combinational and reused by later N-port arbiters.
- Request-field muxing stays inline.

Test Plan:
- s0 read only, addr 0x1000, mem_gnt same cycle, mem_recv 2 cycles later with rdata 0xDEADBEEF, s0_ack=1 -> s0_gnt in cycle 0, s0_recv with rdata 0xDEADBEEF, s1_gnt/s1_recv stay 0, FSM back to IDLE.
- s0 and s1 request in the same cycle after reset -> s1 granted first. With the macro defined, s0 is granted on the next IDLE; with it undefined and s1 still requesting, s1 is granted again.
- s1 write addr 0x20, wdata 0x12345678, strb 0xF, mem_gnt held low 3 cycles -> mem_addr/wdata/strb stable for all 3 cycles; s0_req raised in cycle 1 gets no gnt until s1's response completes.
- Response with mem_error=1 to s1 while s0_ack is held at 1 -> only s1_recv asserts, s1_error=1; mem_ack follows s1_ack, not s0_ack.
- Assert m0_aresetn=0 while in RSP -> all gnt/recv/mem_req/mem_ack go 0 asynchronously; after release, a new s0 request is granted normally.
- Back-to-back s0 requests with zero-latency downstream -> at least one IDLE cycle between s0_recv&&s0_ack and the next s0_gnt.
